// File: rtl/sc_test_ctrl.sv
// rtl/sc_test_ctrl.sv - run controller: sequences core reset, counts run cycles, snoops tohost reports
// Results are latched on the RUN->DONE edge and held until the next start or reset.
module sc_test_ctrl #(
  parameter int                NUM_DUT        = 1,
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                CNT_W          = 32,
  parameter int                RST_CYCLES     = 3,
  parameter int                TIMEOUT_CYCLES = 1000,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h0000_7FFC
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [NUM_DUT-1:0]        i_st_en,
  input  logic [NUM_DUT*ADDR_W-1:0] i_st_addr,
  input  logic [NUM_DUT*DATA_W-1:0] i_st_data,
  output logic                      o_dut_rst_n,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_pass,
  output logic                      o_timeout,
  output logic [NUM_DUT-1:0]        o_done_mask,
  output logic [NUM_DUT-1:0]        o_fail_mask,
  output logic [DATA_W-1:0]         o_fail_code,
  output logic [CNT_W-1:0]          o_cycle_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RESET = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int         RC_W    = $clog2(RST_CYCLES + 1);

  logic [1:0]         state;
  logic [RC_W-1:0]    rst_cnt;
  logic [NUM_DUT-1:0] rep;
  logic [NUM_DUT-1:0] bad;
  logic [NUM_DUT-1:0] done_nx;
  logic [NUM_DUT-1:0] fail_nx;
  logic [DATA_W-1:0]  code_nx;
  logic [ADDR_W-1:0]  a;
  logic [DATA_W-1:0]  d;
  logic               found;

  // Only the first tohost store of each core counts; the earliest failing
  // core (by index) owns the fail code, even if it reports later.
  always_comb begin
    rep     = '0;
    bad     = '0;
    code_nx = o_fail_code;
    found   = 1'b0;
    a       = '0;
    d       = '0;
    for (int k = 0; k < NUM_DUT; k++) begin
      a = i_st_addr[k*ADDR_W +: ADDR_W];
      d = i_st_data[k*DATA_W +: DATA_W];
      rep[k] = i_st_en[k] && (a == TOHOST_ADDR) && !o_done_mask[k];
      bad[k] = rep[k] && (d != DATA_W'(1));
    end
    for (int k = 0; k < NUM_DUT; k++) begin
      d = i_st_data[k*DATA_W +: DATA_W];
      if (!found && o_fail_mask[k]) begin
        found = 1'b1;
      end else if (!found && bad[k]) begin
        code_nx = d >> 1;
        found   = 1'b1;
      end
    end
    done_nx = o_done_mask | rep;
    fail_nx = o_fail_mask | bad;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state       <= S_IDLE;
      rst_cnt     <= '0;
      o_dut_rst_n <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_timeout   <= 1'b0;
      o_done_mask <= '0;
      o_fail_mask <= '0;
      o_fail_code <= '0;
      o_cycle_cnt <= '0;
    end else if ((state == S_IDLE || state == S_DONE) && i_start) begin
      state       <= S_RESET;
      rst_cnt     <= '0;
      o_dut_rst_n <= 1'b0;
      o_busy      <= 1'b1;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_timeout   <= 1'b0;
      o_done_mask <= '0;
      o_fail_mask <= '0;
      o_fail_code <= '0;
      o_cycle_cnt <= '0;
    end else begin
      case (state)
        S_RESET: begin
          rst_cnt <= rst_cnt + 1'b1;
          if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
            state       <= S_RUN;
            o_dut_rst_n <= 1'b1;
          end
        end
        S_RUN: begin
          o_cycle_cnt <= o_cycle_cnt + 1'b1;
          o_done_mask <= done_nx;
          o_fail_mask <= fail_nx;
          o_fail_code <= code_nx;
          if (&done_nx) begin
            state     <= S_DONE;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            o_pass    <= (fail_nx == '0);
            o_timeout <= 1'b0;
          end else if (o_cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state     <= S_DONE;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            o_pass    <= 1'b0;
            o_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_test_ctrl.sv
// tb/tb_sc_test_ctrl.sv - table-driven scoreboard bench for sc_test_ctrl (2 cores, timeout 20)
module tb_sc_test_ctrl;

  localparam int NUM_DUT = 2;
  localparam int RST_C   = 3;
  localparam int TMO     = 20;
  localparam logic [31:0] TOHOST = 32'h0000_7FFC;
  localparam logic [31:0] DECOY  = 32'h0000_7FF8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  st_en = '0;
  logic [63:0] st_addr = '0;
  logic [63:0] st_data = '0;
  logic        dut_rst_n, busy, done, pass, tmo;
  logic [1:0]  done_mask, fail_mask;
  logic [31:0] fail_code, cyc_cnt;

  sc_test_ctrl #(
    .NUM_DUT(NUM_DUT), .ADDR_W(32), .DATA_W(32), .CNT_W(32),
    .RST_CYCLES(RST_C), .TIMEOUT_CYCLES(TMO), .TOHOST_ADDR(TOHOST)
  ) dut (
    .i_clk(clk), .i_reset(rstn), .i_start(start),
    .i_st_en(st_en), .i_st_addr(st_addr), .i_st_data(st_data),
    .o_dut_rst_n(dut_rst_n), .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_timeout(tmo), .o_done_mask(done_mask), .o_fail_mask(fail_mask),
    .o_fail_code(fail_code), .o_cycle_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c0_cyc;
    logic [31:0] c0_dat;
    int          c1_cyc;
    logic [31:0] c1_dat;
    int          rs_cyc;
    int          decoy_cyc;
    logic [1:0]  e_done;
    logic [1:0]  e_fail;
    logic [31:0] e_code;
    logic        e_pass;
    logic        e_to;
    int          e_cnt;
  } vec_t;

  vec_t vecs[8];
  vec_t expq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cycle(input int cyc, input vec_t v);
    st_en = '0;
    st_addr = '0;
    st_data = '0;
    if (cyc == v.c0_cyc) begin
      st_en[0] = 1'b1; st_addr[31:0] = TOHOST; st_data[31:0] = v.c0_dat;
    end else if (cyc == v.rs_cyc) begin
      st_en[0] = 1'b1; st_addr[31:0] = TOHOST; st_data[31:0] = 32'd9;
    end else if (cyc == v.decoy_cyc) begin
      st_en[0] = 1'b1; st_addr[31:0] = DECOY; st_data[31:0] = 32'd1;
    end
    if (cyc == v.c1_cyc) begin
      st_en[1] = 1'b1; st_addr[63:32] = TOHOST; st_data[63:32] = v.c1_dat;
    end
  endtask

  // Pulse start and return once the cores are released (at RUN cycle 0).
  task automatic start_run(output bit ok);
    int lows;
    ok = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("reset_busy", busy, 1'b1);
    check("reset_cleared", {done, pass, tmo, done_mask, fail_mask, fail_code, cyc_cnt}, '0);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (dut_rst_n) break;
      lows++;
      tick();
    end
    if (!dut_rst_n) begin
      check("rst_release_timeout", dut_rst_n, 1'b1);
      return;
    end
    check("rst_low_cycles", lows, RST_C);
    check("run_cnt0", cyc_cnt, 0);
    ok = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    bit   ok;
    int   cyc;
    vec_t e;
    expq.push_back(v);
    start_run(ok);
    if (!ok) return;
    cyc = 0;
    forever begin
      drive_cycle(cyc, v);
      tick();
      if (done) break;
      cyc++;
      if (cyc > 60) begin
        check("done_timeout", done, 1'b1);
        break;
      end
    end
    st_en = '0;
    if (expq.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = expq.pop_front();
    check("done_mask", done_mask, e.e_done);
    check("fail_mask", fail_mask, e.e_fail);
    check("fail_code", fail_code, e.e_code);
    check("pass", pass, e.e_pass);
    check("timeout", tmo, e.e_to);
    check("cycle_cnt", cyc_cnt, e.e_cnt);
    check("done_state", {dut_rst_n, busy}, 2'b10);
  endtask

  initial begin
    //          c0cyc c0dat  c1cyc c1dat rs  decoy done   fail   code pass to  cnt
    vecs[0] = '{9,  32'd1,  9,  32'd1,  -1, -1, 2'b11, 2'b00, 0, 1'b1, 1'b0, 10};
    vecs[1] = '{4,  32'd7,  4,  32'd1,  -1, -1, 2'b11, 2'b01, 3, 1'b0, 1'b0, 5};
    vecs[2] = '{-1, 32'd0, -1,  32'd0,  -1,  5, 2'b00, 2'b00, 0, 1'b0, 1'b1, 20};
    vecs[3] = '{5,  32'd1, 12,  32'd5,   8, -1, 2'b11, 2'b10, 2, 1'b0, 1'b0, 13};
    vecs[4] = '{3,  32'd1, 19,  32'd1,  -1, -1, 2'b11, 2'b00, 0, 1'b1, 1'b0, 20};
    vecs[5] = '{6,  32'd9,  6,  32'd7,  -1, -1, 2'b11, 2'b11, 4, 1'b0, 1'b0, 7};
    vecs[6] = '{6,  32'd3,  2,  32'hB,  -1, -1, 2'b11, 2'b11, 1, 1'b0, 1'b0, 7};
    vecs[7] = '{2,  32'd1, -1,  32'd0,  -1, -1, 2'b01, 2'b00, 0, 1'b0, 1'b1, 20};

    repeat (3) tick();
    check("por_outputs", {dut_rst_n, busy, done, pass, tmo, done_mask, fail_mask, fail_code, cyc_cnt}, '0);
    rstn = 1'b1;
    tick();
    check("idle_outputs", {dut_rst_n, busy, done}, 3'b000);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // start is ignored in RUN; reset mid-run drops everything
    begin
      bit ok;
      start_run(ok);
      if (ok) begin
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ignored_run", {dut_rst_n, busy, done, cyc_cnt}, {3'b110, 32'd3});
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("midrun_reset", {dut_rst_n, busy, done, pass, tmo, done_mask, fail_mask, fail_code, cyc_cnt}, '0);
        tick();
        check("idle_after_reset", {dut_rst_n, busy, done}, 3'b000);
      end
    end

    for (int i = 4; i < 8; i++) run_vec(vecs[i]);

    // DONE freezes results even if core1 reports late
    st_en = 2'b10;
    st_addr[63:32] = TOHOST;
    st_data[63:32] = 32'd1;
    tick();
    tick();
    st_en = '0;
    check("done_frozen", {done, tmo, done_mask, cyc_cnt}, {2'b11, 2'b01, 32'd20});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
